if_id_reg: RTL
==============

# if_id_reg

Pipeline register between the fetch stage and the decode stage. It captures the fetched instruction and its PC values every cycle, and holds them under the same hold signal that freezes the PC register. On a taken branch or jump it replaces them with a NOP bubble. It also keeps saturating counters of stall and flush cycles for performance debug.

## Interface

Parameters:
- WIDTH, default 32: width of the PC and instruction datapath.
- NOP, default 32'h00000013: bubble instruction inserted on flush or reset.
- CNTW, default 16: width of each performance counter.

Ports:
- clk  input  1: rising-edge clock; the block's only clock.
- reset  input  1: asynchronous, active-low; asserted when 0.
- PCF  input  WIDTH: fetch-stage PC.
- PCPlus4F  input  WIDTH: fetch-stage PC+4.
- InstrF  input  WIDTH: instruction read from instruction memory.
- IFIDWrite  input  1: hold control.
  - 1 = hold the current contents; 0 = load.
  - Same polarity as the PC register's PCWrite; the hazard unit drives both from one signal.
- FlushD  input  1: 1 = load a bubble on this edge.
- CntClear  input  1: synchronous clear of both counters.
- InstrD  output  WIDTH: decode-stage instruction.
- PCD  output  WIDTH: decode-stage PC.
- PCPlus4D  output  WIDTH: decode-stage PC+4.
- ValidD  output  1: 1 = InstrD is a real fetched instruction; 0 = bubble.
- StallCnt  output  CNTW: cycles spent holding.
- FlushCnt  output  CNTW: cycles spent flushing.

## Operation

Pipeline register, evaluated at each rising clk edge (reset excepted). Priority, highest first:
- reset low (asynchronous, immediate): InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0.
- FlushD=1: InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0. Flush wins over IFIDWrite=1.
- IFIDWrite=1 (and FlushD=0): all four outputs keep their current values, including ValidD.
- Otherwise (load): InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.

Performance counters, evaluated at each rising clk edge:
- StallCnt increments in a cycle with IFIDWrite=1 and FlushD=0. A cycle with both asserted counts as a flush only.
- FlushCnt increments in a cycle with FlushD=1.
- Both counters saturate at all-ones and never wrap.
- CntClear=1 sets both counters to 0 on the edge. It overrides an increment in the same cycle.
- reset low sets both counters to 0 asynchronously.

General rules:
- Counters are independent of the datapath. CntClear never affects InstrD, PCD, PCPlus4D or ValidD.
- No combinational path from any input to any output; all outputs come straight from flops.

## Timing

- Latency: exactly 1 cycle from the F-stage inputs to the D-stage outputs on a load edge.
- Hold: while IFIDWrite=1, the outputs are stable for every cycle it is asserted. The load resumes on the first edge with IFIDWrite=0.
- Flush: a bubble is visible in the cycle after the FlushD edge. If FlushD stays high, the bubble persists for each such cycle.
- Reset deassertion: the outputs stay at their reset values until the first edge with reset=1. That edge applies the normal priority rules.
  - With IFIDWrite=1 on that edge, the block holds the bubble (ValidD=0).
- Reset mid-operation: all outputs and counters go to their reset values immediately, without waiting for a clock edge. No partial state survives.
- Counter at all-ones plus an increment condition: the value stays at all-ones. An all-ones counter with CntClear=1 goes to 0.

## Test plan

- Reset then load: hold reset=0 for 2 cycles, release, then drive PCF=0x100, PCPlus4F=0x104, InstrF=0x00500093 with IFIDWrite=0 for one edge.
  - Required: all outputs at their reset values during reset (InstrD=0x00000013, ValidD=0).
  - Required: after the edge, InstrD=0x00500093, PCD=0x100, PCPlus4D=0x104, ValidD=1.
- Stall: with a loaded instruction, hold IFIDWrite=1 for 3 cycles while the F-stage inputs change every cycle.
  - Required: outputs unchanged for all 3 cycles; StallCnt=3; FlushCnt=0.
- Flush over stall: assert FlushD=1 and IFIDWrite=1 together for 1 cycle.
  - Required: InstrD=0x00000013, PCD=0, ValidD=0; FlushCnt increments by 1; StallCnt unchanged.
- Counter saturation and clear: use CNTW=4 and hold IFIDWrite=1 for 20 cycles.
  - Required: StallCnt=0xF and stays there.
  - Then assert CntClear=1 together with IFIDWrite=1 for one edge. Required: StallCnt=0 on that edge.
- Asynchronous reset mid-operation: pull reset low between clock edges while ValidD=1 and StallCnt≠0.
  - Required: outputs and both counters return to their reset values before the next rising edge.
- Reset release under hold: release reset with IFIDWrite=1 held for 2 edges, then set IFIDWrite=0.
  - Required: ValidD=0 for the 2 edges, then the F-stage values loaded on the next edge.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch-stage PC, PC+4 and instruction for decode,
// with hold, flush-to-bubble, and saturating stall/flush performance counters.
module if_id_reg #(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   NOP   = 32'h00000013,
    parameter int                 CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PCF,
    input  logic [WIDTH-1:0] PCPlus4F,
    input  logic [WIDTH-1:0] InstrF,
    input  logic             IFIDWrite,
    input  logic             FlushD,
    input  logic             CntClear,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD,
    output logic [CNTW-1:0]  StallCnt,
    output logic [CNTW-1:0]  FlushCnt
);

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic             valid_q, valid_d;
    logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0]  flush_cnt_q, flush_cnt_d;

    logic stall_cycle;
    assign stall_cycle = IFIDWrite && !FlushD;

    // Datapath: flush beats hold, hold beats load.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (FlushD) begin
            instr_d    = NOP;
            pc_d       = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (!IFIDWrite) begin
            instr_d    = InstrF;
            pc_d       = PCF;
            pc_plus4_d = PCPlus4F;
            valid_d    = 1'b1;
        end
    end

    // Counters saturate at all-ones; a simultaneous flush+hold counts only as a flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CntClear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_cycle && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (FlushD && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q     <= NOP;
            pc_q        <= '0;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pc_q;
    assign PCPlus4D = pc_plus4_q;
    assign ValidD   = valid_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule
